systolic_feeder: RTL and testbench



---
 rtl/systolic_feeder.sv | 176 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Skewed A-row / B-column feeder for a SIZE x SIZE systolic array.
// Define SYSTOLIC_FEEDER_ZERO_EN to force data to 0 on lanes whose valid is low.
module systolic_feeder #(
    parameter int SIZE         = 2,
    parameter int IN_WIDTH     = 8,
    parameter int DRAIN_CYCLES = 2 * SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_WIDTH-1:0] in_data [SIZE],
    input  logic                start,
    output logic [IN_WIDTH-1:0] a_in [SIZE],
    output logic [SIZE-1:0]     valid_a,
    output logic [IN_WIDTH-1:0] b_in [SIZE],
    output logic [SIZE-1:0]     valid_b,
    output logic                busy,
    output logic                done
);

    localparam int LC_W = $clog2(2 * SIZE + 1);
    localparam int T_W  = (2 * SIZE - 1 > 1) ? $clog2(2 * SIZE - 1) : 1;
    localparam int DR_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [LC_W-1:0] LC_LAST = LC_W'(2 * SIZE - 1);
    localparam logic [T_W-1:0]  T_LAST  = T_W'(2 * SIZE - 2);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(DRAIN_CYCLES - 1);

`ifdef SYSTOLIC_FEEDER_ZERO_EN
    localparam bit ZERO_IDLE = 1'b1;
`else
    localparam bit ZERO_IDLE = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_LOAD,
        S_ARMED,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [LC_W-1:0] load_cnt_q, load_cnt_d;
    logic [T_W-1:0]  t_q, t_d;
    logic [DR_W-1:0] drain_cnt_q, drain_cnt_d;

    logic [IN_WIDTH-1:0] a_buf_q [SIZE][SIZE];
    logic [IN_WIDTH-1:0] a_buf_d [SIZE][SIZE];
    logic [IN_WIDTH-1:0] b_buf_q [SIZE][SIZE];
    logic [IN_WIDTH-1:0] b_buf_d [SIZE][SIZE];

    logic [IN_WIDTH-1:0] a_in_q [SIZE];
    logic [IN_WIDTH-1:0] a_in_d [SIZE];
    logic [IN_WIDTH-1:0] b_in_q [SIZE];
    logic [IN_WIDTH-1:0] b_in_d [SIZE];
    logic [SIZE-1:0]     valid_a_q, valid_a_d;
    logic [SIZE-1:0]     valid_b_q, valid_b_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        load_cnt_d  = load_cnt_q;
        t_d         = t_q;
        drain_cnt_d = drain_cnt_q;
        a_buf_d     = a_buf_q;
        b_buf_d     = b_buf_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    for (int r = 0; r < SIZE; r++) begin
                        if (int'(load_cnt_q) == r)        a_buf_d[r] = in_data;
                        if (int'(load_cnt_q) == SIZE + r) b_buf_d[r] = in_data;
                    end
                    load_cnt_d = load_cnt_q + LC_W'(1);
                    if (load_cnt_q == LC_LAST) state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (start) begin
                    state_d = S_FEED;
                    t_d     = '0;
                end
            end
            S_FEED: begin
                if (t_q == T_LAST) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt_q == DR_LAST) state_d = S_DONE;
                else drain_cnt_d = drain_cnt_q + DR_W'(1);
            end
            S_DONE: begin
                state_d    = S_LOAD;
                load_cnt_d = '0;
            end
            default: state_d = S_LOAD;
        endcase

        // Outputs are computed from the next state so they line up with it after the edge.
        busy_d     = (state_d == S_FEED) || (state_d == S_DRAIN);
        done_d     = (state_d == S_DONE);
        in_ready_d = (state_d == S_LOAD);

        for (int i = 0; i < SIZE; i++) begin
            int k;
            k = int'(t_d) - i;
            valid_a_d[i] = (state_d == S_FEED) && (k >= 0) && (k < SIZE);
            valid_b_d[i] = valid_a_d[i];
            a_in_d[i]    = ZERO_IDLE ? '0 : a_in_q[i];
            b_in_d[i]    = ZERO_IDLE ? '0 : b_in_q[i];
            if (valid_a_d[i]) begin
                for (int c = 0; c < SIZE; c++) begin
                    if (c == k) begin
                        a_in_d[i] = a_buf_q[i][c];
                        b_in_d[i] = b_buf_q[c][i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            load_cnt_q  <= '0;
            t_q         <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_a_q   <= '0;
            valid_b_q   <= '0;
            for (int i = 0; i < SIZE; i++) begin
                a_in_q[i] <= '0;
                b_in_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            t_q         <= t_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_a_q   <= valid_a_d;
            valid_b_q   <= valid_b_d;
            a_in_q      <= a_in_d;
            b_in_q      <= b_in_d;
        end
    end

    // Matrix storage is data only; its contents are irrelevant until fully reloaded.
    always_ff @(posedge clk) begin
        a_buf_q <= a_buf_d;
        b_buf_q <= b_buf_d;
    end

    assign in_ready = in_ready_q;
    assign a_in     = a_in_q;
    assign b_in     = b_in_q;
    assign valid_a  = valid_a_q;
    assign valid_b  = valid_b_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (SIZE=2, DRAIN_CYCLES=4) with an expected-beat queue.
module tb_systolic_feeder;

    localparam int S  = 2;
    localparam int W  = 8;
    localparam int DR = 4;

`ifdef SYSTOLIC_FEEDER_ZERO_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data [S];
    logic         start;
    logic [W-1:0] a_in [S];
    logic [S-1:0] valid_a;
    logic [W-1:0] b_in [S];
    logic [S-1:0] valid_b;
    logic         busy;
    logic         done;

    systolic_feeder #(.SIZE(S), .IN_WIDTH(W), .DRAIN_CYCLES(DR)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .start(start),
        .a_in(a_in), .valid_a(valid_a),
        .b_in(b_in), .valid_b(valid_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [S-1:0]        va;
        logic [S-1:0]        vb;
        logic [S-1:0][W-1:0] a;
        logic [S-1:0][W-1:0] b;
        logic                busy;
        logic                done;
        logic                rdy;
    } beat_t;

    beat_t sb[$];
    int n_cmp  = 0;
    int n_fail = 0;

    logic [W-1:0] ma [S][S];
    logic [W-1:0] mb [S][S];
    logic [W-1:0] last_a [S];
    logic [W-1:0] last_b [S];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_va"}, 32'(valid_a), 32'd0);
        chk({tag, "_vb"}, 32'(valid_b), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < S; i++) begin
            last_a[i] = '0;
            last_b[i] = '0;
        end
    endtask

    function automatic beat_t idle_beat();
        beat_t e;
        e = '0;
        for (int i = 0; i < S; i++) begin
            e.a[i] = ZERO ? '0 : last_a[i];
            e.b[i] = ZERO ? '0 : last_b[i];
        end
        return e;
    endfunction

    // Expected sequence for one start: 2*S-1 feed beats, DR drain beats, done, back to load.
    task automatic push_run();
        beat_t e;
        for (int t = 0; t < 2 * S - 1; t++) begin
            e = idle_beat();
            e.busy = 1'b1;
            for (int i = 0; i < S; i++) begin
                int k;
                k = t - i;
                if (k >= 0 && k < S) begin
                    e.va[i]   = 1'b1;
                    e.vb[i]   = 1'b1;
                    last_a[i] = ma[i][k];
                    last_b[i] = mb[k][i];
                    e.a[i]    = last_a[i];
                    e.b[i]    = last_b[i];
                end
            end
            sb.push_back(e);
        end
        for (int d = 0; d < DR; d++) begin
            e = idle_beat();
            e.busy = 1'b1;
            sb.push_back(e);
        end
        e = idle_beat();
        e.done = 1'b1;
        sb.push_back(e);
        e = idle_beat();
        e.rdy = 1'b1;
        sb.push_back(e);
    endtask

    task automatic check_beat(input string tag);
        beat_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected a pending beat", tag);
        end
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({tag, "_va"}, 32'(valid_a), 32'(e.va));
        chk({tag, "_vb"}, 32'(valid_b), 32'(e.vb));
        for (int i = 0; i < S; i++) begin
            chk($sformatf("%s_a%0d", tag, i), 32'(a_in[i]), 32'(e.a[i]));
            chk($sformatf("%s_b%0d", tag, i), 32'(b_in[i]), 32'(e.b[i]));
        end
        chk({tag, "_busy"}, 32'(busy), 32'(e.busy));
        chk({tag, "_done"}, 32'(done), 32'(e.done));
        chk({tag, "_rdy"}, 32'(in_ready), 32'(e.rdy));
    endtask

    task automatic load_beat(input logic [W-1:0] c0, input logic [W-1:0] c1);
        in_valid   = 1'b1;
        in_data[0] = c0;
        in_data[1] = c1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic load_all();
        load_beat(8'd1, 8'd2);
        load_beat(8'd3, 8'd4);
        load_beat(8'd1, 8'd2);
        load_beat(8'd4, 8'd5);
        chk("load_rdy_low", 32'(in_ready), 32'd0);
    endtask

    task automatic run_feed(input string tag, input bit drain_start);
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_beat({tag, "_t0"});
        tick();
        check_beat({tag, "_t1"});
        chk({tag, "_tp_a0"}, 32'(a_in[0]), 32'd2);
        chk({tag, "_tp_a1"}, 32'(a_in[1]), 32'd3);
        chk({tag, "_tp_b0"}, 32'(b_in[0]), 32'd4);
        chk({tag, "_tp_b1"}, 32'(b_in[1]), 32'd2);
        tick();
        check_beat({tag, "_t2"});
        chk({tag, "_tp2_a1"}, 32'(a_in[1]), 32'd4);
        chk({tag, "_tp2_b1"}, 32'(b_in[1]), 32'd5);
        chk({tag, "_tp2_a0"}, 32'(a_in[0]), ZERO ? 32'd0 : 32'd2);
        chk({tag, "_tp2_b0"}, 32'(b_in[0]), ZERO ? 32'd0 : 32'd4);
        for (int d = 0; d < DR + 2; d++) begin
            if (drain_start && d == 1) start = 1'b1;
            tick();
            start = 1'b0;
            check_beat($sformatf("%s_post%0d", tag, d));
        end
    endtask

    initial begin
        ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
        mb[0][0] = 8'd1; mb[0][1] = 8'd2; mb[1][0] = 8'd4; mb[1][1] = 8'd5;
        model_reset();

        reset      = 1'b1;
        in_valid   = 1'b0;
        start      = 1'b0;
        in_data[0] = '0;
        in_data[1] = '0;
        tick();
        tick();
        chk_idle("rst");
        chk("rst_rdy", 32'(in_ready), 32'd1);
        for (int i = 0; i < S; i++) begin
            chk($sformatf("rst_a%0d", i), 32'(a_in[i]), 32'd0);
            chk($sformatf("rst_b%0d", i), 32'(b_in[i]), 32'd0);
        end
        reset = 1'b0;

        // Load with a one-cycle stall and a start pulse after two beats.
        load_beat(8'd1, 8'd2);
        load_beat(8'd3, 8'd4);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_idle("stall");
        chk("stall_rdy", 32'(in_ready), 32'd1);
        load_beat(8'd1, 8'd2);
        chk("beat3_rdy", 32'(in_ready), 32'd1);
        load_beat(8'd4, 8'd5);
        chk("beat4_rdy", 32'(in_ready), 32'd0);

        // Beat offered while armed must not touch the buffers.
        load_beat(8'd9, 8'd9);
        chk_idle("armed");
        chk("armed_rdy", 32'(in_ready), 32'd0);
        tick();
        chk_idle("armed_wait");

        run_feed("run1", 1'b1);
        chk("sb_empty1", 32'(sb.size()), 32'd0);

        // Abort in the middle of the feed.
        load_all();
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_beat("abort_t0");
        tick();
        check_beat("abort_t1");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        model_reset();
        chk_idle("abort");
        chk("abort_rdy", 32'(in_ready), 32'd1);
        chk("abort_a0", 32'(a_in[0]), 32'd0);
        chk("abort_b1", 32'(b_in[1]), 32'd0);
        for (int c = 0; c < DR + 3; c++) begin
            tick();
            chk($sformatf("abort_nodone%0d", c), 32'(done), 32'd0);
            chk($sformatf("abort_rdy%0d", c), 32'(in_ready), 32'd1);
        end

        load_all();
        run_feed("run2", 1'b0);
        chk("sb_empty2", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
